// File: rtl/mannix_mem_bank_resp.sv
// mannix_mem_bank_resp
// Memory-side responder for the mannix line read/write request channels.
// Serves one request at a time out of a single word bank.
//   - Write: the line is committed at the accepting edge; wr_gnt pulses once.
//   - Read : address/size are latched at the accepting edge (rd_gnt pulse);
//            the line is returned RD_LATENCY cycles later with a rd_valid pulse.
//   - A line that crosses DEPTH-1 wraps to address 0; address bits above
//     $clog2(DEPTH) are ignored.
// Optional feature (macro MANNIX_MEM_RESP_OOR_ERR_EN):
//   adds resp_err. Requests with nonzero high address bits, or whose line runs
//   past DEPTH-1, are out of range. Such writes write nothing, such reads return
//   zeros, and resp_err pulses together with wr_gnt / rd_valid.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rd_req/addr/size    read request (held until rd_gnt); size 0 = full line
//   rd_gnt              one-cycle read acceptance pulse
//   rd_valid, rd_data   one-cycle data valid pulse, returned line (word i at
//                       bits [i*WORD_WIDTH +: WORD_WIDTH]); rd_data holds
//   wr_req/addr/size    write request (held until wr_gnt)
//   wr_data             write line, same packing as rd_data
//   wr_gnt              one-cycle write acceptance/completion pulse
//   busy                high whenever the FSM is not IDLE
//   resp_err            (macro only) out-of-range indication
//
// The bank is split word-interleaved into NUM_WORDS_IN_LINE sub-banks
// (address mod NUM_WORDS_IN_LINE selects the sub-bank), so any line of
// consecutive addresses touches each sub-bank at most once and every sub-bank
// needs only one write port and one read port.

module mannix_mem_bank_resp #(
    parameter int ADDR_WIDTH        = 19,
    parameter int WORD_WIDTH        = 8,
    parameter int NUM_WORDS_IN_LINE = 32,
    parameter int DEPTH             = 4096,
    parameter int RD_LATENCY        = 2,
    parameter int SIZE_W            = $clog2(NUM_WORDS_IN_LINE) + 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    rd_req,
    input  logic [ADDR_WIDTH-1:0]                   rd_addr,
    input  logic [SIZE_W-1:0]                       rd_size,
    output logic                                    rd_gnt,
    output logic                                    rd_valid,
    output logic [NUM_WORDS_IN_LINE*WORD_WIDTH-1:0] rd_data,
    input  logic                                    wr_req,
    input  logic [ADDR_WIDTH-1:0]                   wr_addr,
    input  logic [SIZE_W-1:0]                       wr_size,
    input  logic [NUM_WORDS_IN_LINE*WORD_WIDTH-1:0] wr_data,
    output logic                                    wr_gnt,
    output logic                                    busy
`ifdef MANNIX_MEM_RESP_OOR_ERR_EN
    ,
    output logic                                    resp_err
`endif
);

    localparam int LINE_W = NUM_WORDS_IN_LINE * WORD_WIDTH;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int OFF_W  = $clog2(NUM_WORDS_IN_LINE);
    localparam int ROW_W  = IDX_W - OFF_W;
    localparam int ROWS   = DEPTH / NUM_WORDS_IN_LINE;
    localparam int CNT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_ACK  = 2'd2
    } state_t;

    // Size 0 (and anything larger than a line) means a full line.
    function automatic logic [SIZE_W-1:0] eff_size(input logic [SIZE_W-1:0] s);
        if (s == '0 || s > SIZE_W'(NUM_WORDS_IN_LINE))
            return SIZE_W'(NUM_WORDS_IN_LINE);
        else
            return s;
    endfunction

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                rd_gnt_next, wr_gnt_next, rd_valid_next, err_next;
    logic                rd_accept, wr_accept;
    logic [IDX_W-1:0]    rd_base_reg;
    logic [SIZE_W-1:0]   rd_n_reg;
    logic                rd_oor_reg;
    logic [SIZE_W-1:0]   wr_n, rd_n_in;
    logic                wr_oor, rd_oor_in;
    logic [LINE_W-1:0]   bank_rd;   // word gi = sub-bank gi output
    logic [LINE_W-1:0]   line_rd;   // rotated and masked line

    assign wr_n    = eff_size(wr_size);
    assign rd_n_in = eff_size(rd_size);

`ifdef MANNIX_MEM_RESP_OOR_ERR_EN
    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a,
                                          input logic [SIZE_W-1:0]     n);
        logic [IDX_W:0] end_w;
        end_w = {1'b0, a[IDX_W-1:0]} + (IDX_W+1)'(n);
        return ((a >> IDX_W) != '0) || (end_w > (IDX_W+1)'(DEPTH));
    endfunction

    assign wr_oor    = out_of_range(wr_addr, wr_n);
    assign rd_oor_in = out_of_range(rd_addr, rd_n_in);
`else
    logic unused_sink;
    assign wr_oor      = 1'b0;
    assign rd_oor_in   = 1'b0;
    assign unused_sink = ^{rd_addr, wr_addr, err_next};
`endif

    // ------------------------------------------------------------------
    // FSM: next state and registered-output next values
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        rd_gnt_next   = 1'b0;
        wr_gnt_next   = 1'b0;
        rd_valid_next = 1'b0;
        err_next      = 1'b0;
        rd_accept     = 1'b0;
        wr_accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                // A request still held during our own grant cycle must not be
                // accepted a second time.
                if (!rd_gnt && !wr_gnt) begin
                    if (wr_req) begin
                        wr_accept   = 1'b1;
                        wr_gnt_next = 1'b1;
                        err_next    = wr_oor;
                        state_next  = WR_ACK;
                    end else if (rd_req) begin
                        rd_accept   = 1'b1;
                        rd_gnt_next = 1'b1;
                        cnt_next    = CNT_W'(RD_LATENCY - 1);
                        state_next  = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_reg == '0) begin
                    rd_valid_next = 1'b1;
                    err_next      = rd_oor_reg;
                    state_next    = IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            WR_ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            rd_gnt      <= 1'b0;
            wr_gnt      <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            rd_base_reg <= '0;
            rd_n_reg    <= '0;
            rd_oor_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rd_gnt    <= rd_gnt_next;
            wr_gnt    <= wr_gnt_next;
            rd_valid  <= rd_valid_next;
            if (rd_accept) begin
                rd_base_reg <= rd_addr[IDX_W-1:0];
                rd_n_reg    <= rd_n_in;
                rd_oor_reg  <= rd_oor_in;
            end
            if (rd_valid_next) begin
                rd_data <= line_rd;
            end
        end
    end

`ifdef MANNIX_MEM_RESP_OOR_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_err <= 1'b0;
        end else begin
            resp_err <= err_next;
        end
    end
`endif

    assign busy = (state_reg != IDLE);

    // ------------------------------------------------------------------
    // Word-interleaved sub-banks
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS_IN_LINE; gi++) begin : g_bank
            logic [WORD_WIDTH-1:0] mem [ROWS];
            logic [OFF_W-1:0]      wr_off;
            logic [ROW_W-1:0]      wr_row, rd_row;
            logic                  wr_en;

            // Offset of this sub-bank's word within the incoming line.
            assign wr_off = OFF_W'(gi) - wr_addr[OFF_W-1:0];
            // Sub-banks below the start offset hold words of the next row;
            // the row adder wraps modulo DEPTH by width.
            assign wr_row = wr_addr[IDX_W-1:OFF_W]
                          + ROW_W'(OFF_W'(gi) < wr_addr[OFF_W-1:0]);
            assign wr_en  = wr_accept && !wr_oor && (SIZE_W'(wr_off) < wr_n);

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem[wr_row] <= wr_data[wr_off*WORD_WIDTH +: WORD_WIDTH];
                end
            end

            assign rd_row = rd_base_reg[IDX_W-1:OFF_W]
                          + ROW_W'(OFF_W'(gi) < rd_base_reg[OFF_W-1:0]);
            assign bank_rd[gi*WORD_WIDTH +: WORD_WIDTH] = mem[rd_row];
        end

        // Output word gi comes from sub-bank (base + gi) mod line length.
        for (gi = 0; gi < NUM_WORDS_IN_LINE; gi++) begin : g_word
            logic [OFF_W-1:0] src;
            assign src = rd_base_reg[OFF_W-1:0] + OFF_W'(gi);
            assign line_rd[gi*WORD_WIDTH +: WORD_WIDTH] =
                (!rd_oor_reg && (SIZE_W'(gi) < rd_n_reg))
                    ? bank_rd[src*WORD_WIDTH +: WORD_WIDTH] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_mannix_mem_bank_resp.sv
// Self-checking bench for mannix_mem_bank_resp: table-driven directed
// vectors, hand-written multi-cycle sequences and randomized traffic
// compared against a flat word-array reference model.
module tb_mannix_mem_bank_resp;

    localparam int AW    = 19;
    localparam int WW    = 8;
    localparam int NW    = 32;
    localparam int DEPTH = 4096;
    localparam int LAT   = 2;
    localparam int SW    = 6;
    localparam int LW    = NW * WW;
`ifdef MANNIX_MEM_RESP_OOR_ERR_EN
    localparam bit OOR_EN = 1'b1;
`else
    localparam bit OOR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [SW-1:0] rd_size = '0;
    logic          rd_gnt, rd_valid;
    logic [LW-1:0] rd_data;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [SW-1:0] wr_size = '0;
    logic [LW-1:0] wr_data = '0;
    logic          wr_gnt, busy;
`ifdef MANNIX_MEM_RESP_OOR_ERR_EN
    logic          resp_err;
`endif

    always #5 clk = ~clk;

    mannix_mem_bank_resp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_size  (rd_size),
        .rd_gnt   (rd_gnt),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_size  (wr_size),
        .wr_data  (wr_data),
        .wr_gnt   (wr_gnt),
        .busy     (busy)
`ifdef MANNIX_MEM_RESP_OOR_ERR_EN
        ,
        .resp_err (resp_err)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Reference model: flat word array addressed modulo DEPTH.
    logic [WW-1:0] model_mem [DEPTH];

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int eff(input logic [SW-1:0] s);
        return (s == 0 || s > NW) ? NW : int'(s);
    endfunction

    function automatic bit model_oor(input logic [AW-1:0] a, input logic [SW-1:0] s);
        return OOR_EN && ((int'(a) >= DEPTH) || (int'(a) + eff(s) > DEPTH));
    endfunction

    function automatic logic [LW-1:0] model_read(input logic [AW-1:0] a, input logic [SW-1:0] s);
        logic [LW-1:0] line;
        line = '0;
        if (!model_oor(a, s))
            for (int i = 0; i < eff(s); i++)
                line[i*WW +: WW] = model_mem[(int'(a) + i) % DEPTH];
        return line;
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [SW-1:0] s, input logic [LW-1:0] d);
        if (!model_oor(a, s))
            for (int i = 0; i < eff(s); i++)
                model_mem[(int'(a) + i) % DEPTH] = d[i*WW +: WW];
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic do_write(input logic [AW-1:0] a, input logic [SW-1:0] s, input logic [LW-1:0] d);
        wr_addr = a; wr_size = s; wr_data = d; wr_req = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            if (wr_gnt) break;
        end
        chk("wr_gnt", wr_gnt, 1);
        chk("wr_busy", busy, 1);
`ifdef MANNIX_MEM_RESP_OOR_ERR_EN
        chk("wr_resp_err", resp_err, model_oor(a, s));
`endif
        wr_req = 1'b0;
        model_write(a, s, d);
        @(posedge clk); #1;
        chk("wr_gnt_pulse", wr_gnt, 0);
        chk("wr_busy_done", busy, 0);
        $display("WR addr=%05h size=%0d", a, s);
    endtask

    task automatic finish_read(input logic [AW-1:0] a, input logic [SW-1:0] s, output logic [LW-1:0] got);
        logic [LW-1:0] exp;
        int c;
        exp = model_read(a, s);
        c = 0;
        for (int i = 1; i <= LAT + 3; i++) begin
            @(posedge clk); #1;
            if (rd_valid) begin c = i; break; end
        end
        chk("rd_latency", c, LAT);
        chk("rd_data", rd_data, exp);
        chk("rd_busy_done", busy, 0);
`ifdef MANNIX_MEM_RESP_OOR_ERR_EN
        chk("rd_resp_err", resp_err, model_oor(a, s));
`endif
        got = rd_data;
        @(posedge clk); #1;
        chk("rd_valid_pulse", rd_valid, 0);
        chk("rd_data_hold", rd_data, exp);
        $display("RD addr=%05h size=%0d latency=%0d", a, s, c);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [SW-1:0] s, output logic [LW-1:0] got);
        rd_addr = a; rd_size = s; rd_req = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            if (rd_gnt) break;
        end
        chk("rd_gnt", rd_gnt, 1);
        chk("rd_busy", busy, 1);
        rd_req = 1'b0;
        finish_read(a, s, got);
    endtask

    typedef struct {
        string         name;
        logic [AW-1:0] pa;   // prefill full line at pa with byte pv
        logic [WW-1:0] pv;
        logic [AW-1:0] wa;   // then write: word i = wb + i
        logic [SW-1:0] ws;
        logic [WW-1:0] wb;
        logic [AW-1:0] ra;   // then read
        logic [SW-1:0] rs;
        logic [63:0]   exp8; // required words 0..7 of the read line
    } vec_t;

    vec_t vecs[$];

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [LW-1:0] got, line;
        logic [AW-1:0] a;
        logic [SW-1:0] s;
        int e;
        bit seen;

        vecs.push_back('{"full_line",  19'h010, 8'h00, 19'h010, 6'd0, 8'h01, 19'h010, 6'd0, 64'h0807060504030201});
        vecs.push_back('{"partial",    19'h100, 8'hFF, 19'h100, 6'd5, 8'hA0, 19'h100, 6'd8, 64'hFFFFFFA4A3A2A1A0});
        vecs.push_back('{"unaligned",  19'h3C0, 8'h20, 19'h3C5, 6'd3, 8'h70, 19'h3C4, 6'd5, 64'h0000002072717020});
`ifndef MANNIX_MEM_RESP_OOR_ERR_EN
        vecs.push_back('{"wrap",       19'h000, 8'h11, 19'hFFE, 6'd4, 8'h01, 19'h000, 6'd2, 64'h0000000000000403});
        vecs.push_back('{"high_bits",  19'h234, 8'h33, 19'h41234, 6'd2, 8'h90, 19'h00234, 6'd3, 64'h0000000000339190});
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {rd_gnt, rd_valid, wr_gnt, busy}, 0);
        chk("rst_rd_data", rd_data, 0);
`ifdef MANNIX_MEM_RESP_OOR_ERR_EN
        chk("rst_resp_err", resp_err, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Give every location a known value.
        for (int l = 0; l < DEPTH / NW; l++) do_write(AW'(l * NW), 6'd0, rand_line());

        // Directed table
        foreach (vecs[v]) begin
            do_write(vecs[v].pa, 6'd0, {NW{vecs[v].pv}});
            for (int i = 0; i < NW; i++) line[i*WW +: WW] = vecs[v].wb + WW'(i);
            do_write(vecs[v].wa, vecs[v].ws, line);
            do_read(vecs[v].ra, vecs[v].rs, got);
            chk(vecs[v].name, got[63:0], vecs[v].exp8);
        end

        // Simultaneous requests: write wins, read follows and sees new data.
        line = rand_line();
        wr_addr = 19'h200; wr_size = 6'd0; wr_data = line; wr_req = 1'b1;
        rd_addr = 19'h200; rd_size = 6'd0; rd_req = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            if (wr_gnt || rd_gnt) break;
        end
        chk("sim_wr_first", {wr_gnt, rd_gnt}, 2'b10);
        model_write(19'h200, 6'd0, line);
        wr_req = 1'b0;
        e = 0;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            e++;
            if (rd_gnt) break;
        end
        chk("sim_rd_gap", (rd_gnt && e >= 2), 1);
        rd_req = 1'b0;
        finish_read(19'h200, 6'd0, got);
        chk("sim_new_data", got, {{(LW-LW){1'b0}}, line});

        // Reset one cycle after rd_gnt aborts the read.
        rd_addr = 19'h123; rd_size = 6'd7; rd_req = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            if (rd_gnt) break;
        end
        chk("rstmid_gnt", rd_gnt, 1);
        rd_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_ctrl", {rd_gnt, rd_valid, wr_gnt, busy}, 0);
        chk("rstmid_rd_data", rd_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(posedge clk); #1;
            if (rd_valid) seen = 1'b1;
        end
        chk("rstmid_no_valid", seen, 0);
        do_read(19'h123, 6'd7, got);

`ifdef MANNIX_MEM_RESP_OOR_ERR_EN
        // Out-of-range read returns zeros; out-of-range write changes nothing.
        do_read(19'hFFE, 6'd4, got);
        chk("oor_rd_zero", got, 0);
        do_write(19'hFFE, 6'd4, rand_line());
        do_read(19'hFE0, 6'd0, got);
`endif

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            a = AW'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 7) == 0) a[AW-1:12] = 7'($urandom_range(1, 127));
            s = SW'($urandom_range(0, NW));
            if ($urandom_range(0, 1) == 1) do_write(a, s, rand_line());
            else do_read(a, s, got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
